// File: rtl/counter_defs.sv
// Shared constants and packed-field helper for the cascaded counter.
package counter_defs;

    localparam int unsigned DEF_STAGE_W   = 4;
    localparam int unsigned DEF_DIGIT_MAX = 9;
    localparam int unsigned FIELD_BUS_W   = 256;
    localparam int unsigned FIELD_MAX_W   = 32;

    // Extract field idx of width w from a packed bus (LSB field is index 0).
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [FIELD_BUS_W-1:0] bus,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [FIELD_BUS_W-1:0] shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = (w >= FIELD_MAX_W) ? '1
                                     : ((FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1));
        return FIELD_MAX_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/counter_stage.sv
// One digit of the cascade: up/down modulo-(max+1) counter with clamped load.
module counter_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         at_term,
    output logic         wrap
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] terminal_c;

    // Terminal is max when counting up, zero when counting down.
    assign terminal_c = dir ? '0 : max;
    assign at_term    = (value_q == terminal_c);
    assign wrap       = step & at_term;
    assign value      = value_q;

    // Next value: reset, then clamped load, then a single step.
    always_comb begin
        value_d = value_q;
        if (rst) begin
            value_d = '0;
        end else if (load) begin
            value_d = (load_val > max) ? max : load_val;
        end else if (step) begin
            if (dir) begin
                value_d = (value_q == '0) ? max : value_q - W'(1);
            end else begin
                value_d = (value_q == max) ? '0 : value_q + W'(1);
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit cascaded up/down counter with wrap or saturate and trigger pulses.
module cascade_counter
    import counter_defs::*;
#(
    parameter int unsigned                          NUM_STAGES  = 4,
    parameter int unsigned                          STAGE_WIDTH = DEF_STAGE_W,
    parameter logic [NUM_STAGES*STAGE_WIDTH-1:0]    STAGE_MAX   = 16'h9999,
    parameter bit                                   SATURATE    = 1'b0
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                ENABLE_IN,
    input  logic                                DIR_DOWN,
    input  logic                                LOAD,
    input  logic [NUM_STAGES*STAGE_WIDTH-1:0]   LOAD_VALUE,
    output logic [NUM_STAGES*STAGE_WIDTH-1:0]   COUNT,
    output logic [NUM_STAGES-1:0]               STAGE_TRIG,
    output logic                                TRIG_OUT,
    output logic                                AT_TERMINAL
);

    localparam int unsigned W = STAGE_WIDTH;
    localparam int unsigned N = NUM_STAGES;

    // Parameter sanity; the field helper bounds bus and field widths.
    if (N < 1) begin : g_bad_stages
        $error("cascade_counter: NUM_STAGES must be >= 1");
    end
    if (W < 1 || W > FIELD_MAX_W) begin : g_bad_width
        $error("cascade_counter: STAGE_WIDTH out of range");
    end
    if (N * W > FIELD_BUS_W) begin : g_bad_bus
        $error("cascade_counter: NUM_STAGES*STAGE_WIDTH too wide");
    end

    logic [N-1:0] at_term_c;
    logic [N-1:0] wrap_c;
    logic [N-1:0] step_c;
    logic [N:0]   carry_c;
    logic         hold_c;

    logic [N-1:0] stage_trig_q;
    logic [N-1:0] stage_trig_d;
    logic         trig_q;
    logic         trig_d;

    // One stage per digit; maxima are elaboration constants.
    for (genvar i = 0; i < N; i++) begin : g_stage
        localparam logic [W-1:0] MAX_I = W'(get_field(FIELD_BUS_W'(STAGE_MAX), i, W));

        counter_stage #(
            .W (W)
        ) u_stage (
            .clk      (CLK),
            .rst      (RESET),
            .step     (step_c[i]),
            .dir      (DIR_DOWN),
            .load     (LOAD),
            .load_val (LOAD_VALUE[i*W +: W]),
            .max      (MAX_I),
            .value    (COUNT[i*W +: W]),
            .at_term  (at_term_c[i]),
            .wrap     (wrap_c[i])
        );
    end

    // Carry AND-chain and step gating; saturation freezes every stage.
    always_comb begin
        carry_c    = '0;
        step_c     = '0;
        carry_c[0] = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            carry_c[i+1] = carry_c[i] & at_term_c[i];
        end
        hold_c = SATURATE & ENABLE_IN & carry_c[N];
        for (int i = 0; i < int'(N); i++) begin
            step_c[i] = ENABLE_IN & ~LOAD & ~hold_c & carry_c[i];
        end
    end

    assign AT_TERMINAL = carry_c[N];

    // Trigger pulses, cleared by reset or load.
    always_comb begin
        stage_trig_d = '0;
        trig_d       = 1'b0;
        if (!RESET && !LOAD) begin
            stage_trig_d = wrap_c;
            trig_d       = ENABLE_IN & carry_c[N];
        end
    end

    // Trigger registers.
    always_ff @(posedge CLK) begin
        stage_trig_q <= stage_trig_d;
        trig_q       <= trig_d;
    end

    assign STAGE_TRIG = stage_trig_q;
    assign TRIG_OUT   = trig_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Directed bench for cascade_counter: default BCD, saturating and small mixed-radix instances.
module tb_cascade_counter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Default instance (4 BCD digits, wrapping)
    logic        d_rst = 1'b1, d_en = 1'b0, d_dir = 1'b0, d_load = 1'b0;
    logic [15:0] d_lv = '0;
    logic [15:0] d_cnt;
    logic [3:0]  d_st;
    logic        d_tr, d_at;

    // Saturating instance
    logic        s_rst = 1'b1, s_en = 1'b0, s_dir = 1'b0, s_load = 1'b0;
    logic [15:0] s_lv = '0;
    logic [15:0] s_cnt;
    logic [3:0]  s_st;
    logic        s_tr, s_at;

    // Small instance: 2 stages, 3 bits, maxima 7 (stage 0) and 5 (stage 1)
    logic        m_rst = 1'b1, m_en = 1'b0, m_dir = 1'b0, m_load = 1'b0;
    logic [5:0]  m_lv = '0;
    logic [5:0]  m_cnt;
    logic [1:0]  m_st;
    logic        m_tr, m_at;

    cascade_counter u_def (
        .CLK(CLK), .RESET(d_rst), .ENABLE_IN(d_en), .DIR_DOWN(d_dir), .LOAD(d_load),
        .LOAD_VALUE(d_lv), .COUNT(d_cnt), .STAGE_TRIG(d_st), .TRIG_OUT(d_tr), .AT_TERMINAL(d_at)
    );

    cascade_counter #(.SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RESET(s_rst), .ENABLE_IN(s_en), .DIR_DOWN(s_dir), .LOAD(s_load),
        .LOAD_VALUE(s_lv), .COUNT(s_cnt), .STAGE_TRIG(s_st), .TRIG_OUT(s_tr), .AT_TERMINAL(s_at)
    );

    cascade_counter #(.NUM_STAGES(2), .STAGE_WIDTH(3), .STAGE_MAX(6'o57)) u_small (
        .CLK(CLK), .RESET(m_rst), .ENABLE_IN(m_en), .DIR_DOWN(m_dir), .LOAD(m_load),
        .LOAD_VALUE(m_lv), .COUNT(m_cnt), .STAGE_TRIG(m_st), .TRIG_OUT(m_tr), .AT_TERMINAL(m_at)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          mv;
    int          trig_seen;
    logic [1:0]  m_st_exp;
    logic        m_tr_exp;
    logic        m_at_exp;
    logic        s0_term;
    logic        ch_term;
    logic [2:0]  f1;

    initial begin
        // Reset all instances
        tick();
        check("def_reset_count", 32'(d_cnt), 32'h0);
        check("def_reset_stage_trig", 32'(d_st), 32'h0);
        check("def_reset_trig", 32'(d_tr), 32'h0);
        check("def_reset_at_term_up", 32'(d_at), 32'h0);
        d_dir = 1'b1;
        #1;
        check("def_reset_at_term_down", 32'(d_at), 32'h1);
        d_dir = 1'b0;

        // Count up: first digit wrap after 10 enables
        d_rst = 1'b0;
        d_en  = 1'b1;
        repeat (9) tick();
        check("up9_count", 32'(d_cnt), 32'h0009);
        check("up9_stage_trig", 32'(d_st), 32'h0);
        tick();
        check("up10_count", 32'(d_cnt), 32'h0010);
        check("up10_stage_trig", 32'(d_st), 32'h1);
        tick();
        check("up11_stage_trig", 32'(d_st), 32'h0);
        check("up11_count", 32'(d_cnt), 32'h0011);

        // Run to 9999 enables, counting any early chain triggers
        trig_seen = 0;
        for (int k = 0; k < 9988; k++) begin
            tick();
            if (d_tr) trig_seen++;
        end
        check("up9999_count", 32'(d_cnt), 32'h9999);
        check("up9999_no_early_trig", 32'(trig_seen), 32'd0);
        check("up9999_at_term", 32'(d_at), 32'h1);
        tick();
        check("up10000_count", 32'(d_cnt), 32'h0);
        check("up10000_trig", 32'(d_tr), 32'h1);
        check("up10000_stage_trig", 32'(d_st), 32'hF);
        tick();
        check("up10001_trig_clears", 32'(d_tr), 32'h0);
        check("up10001_count", 32'(d_cnt), 32'h0001);

        // Count down from zero wraps every digit
        d_en  = 1'b0;
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        d_dir = 1'b1;
        d_en  = 1'b1;
        tick();
        check("down_wrap_count", 32'(d_cnt), 32'h9999);
        check("down_wrap_stage_trig", 32'(d_st), 32'hF);
        check("down_wrap_trig", 32'(d_tr), 32'h1);

        // Load beats enable, clamps fields, clears triggers
        d_dir  = 1'b0;
        d_load = 1'b1;
        d_lv   = 16'h3F7A;
        tick();
        check("load_clamp_count", 32'(d_cnt), 32'h3979);
        check("load_stage_trig", 32'(d_st), 32'h0);
        check("load_trig", 32'(d_tr), 32'h0);

        // Reset on the would-be wrap edge suppresses the pulse
        d_en = 1'b0;
        d_lv = 16'h9999;
        tick();
        d_load = 1'b0;
        d_en   = 1'b1;
        d_rst  = 1'b1;
        tick();
        check("rst_wrap_count", 32'(d_cnt), 32'h0);
        check("rst_wrap_stage_trig", 32'(d_st), 32'h0);
        check("rst_wrap_trig", 32'(d_tr), 32'h0);

        // Reset right after a wrap edge clears the visible pulse
        d_rst  = 1'b0;
        d_en   = 1'b0;
        d_load = 1'b1;
        tick();
        d_load = 1'b0;
        d_en   = 1'b1;
        tick();
        check("wrap_before_rst_trig", 32'(d_tr), 32'h1);
        d_rst = 1'b1;
        tick();
        check("rst_after_wrap_count", 32'(d_cnt), 32'h0);
        check("rst_after_wrap_trig", 32'(d_tr), 32'h0);
        check("rst_after_wrap_stage_trig", 32'(d_st), 32'h0);
        d_rst = 1'b0;
        d_en  = 1'b0;

        // Saturating chain holds at terminal and keeps triggering
        s_rst  = 1'b0;
        s_load = 1'b1;
        s_lv   = 16'h9998;
        tick();
        check("sat_load_count", 32'(s_cnt), 32'h9998);
        s_load = 1'b0;
        s_en   = 1'b1;
        tick();
        check("sat_c1_count", 32'(s_cnt), 32'h9999);
        check("sat_c1_trig", 32'(s_tr), 32'h0);
        tick();
        check("sat_c2_count", 32'(s_cnt), 32'h9999);
        check("sat_c2_trig", 32'(s_tr), 32'h1);
        check("sat_c2_stage_trig", 32'(s_st), 32'h0);
        tick();
        check("sat_c3_count", 32'(s_cnt), 32'h9999);
        check("sat_c3_trig", 32'(s_tr), 32'h1);
        s_dir = 1'b1;
        tick();
        check("sat_reverse_count", 32'(s_cnt), 32'h9998);
        check("sat_reverse_trig", 32'(s_tr), 32'h0);
        s_en = 1'b0;

        // Small mixed-radix instance against a modulo-48 model
        tick();
        check("small_reset_count", 32'(m_cnt), 32'h0);
        m_rst = 1'b0;
        mv = 0;
        for (int k = 0; k < 150; k++) begin
            m_en   = ($urandom_range(0, 3) != 0);
            m_dir  = 1'($urandom);
            m_load = ($urandom_range(0, 7) == 0);
            m_lv   = 6'($urandom);
            #1;
            m_at_exp = m_dir ? (mv == 0) : (mv == 47);
            check("small_at_term", 32'(m_at), 32'(m_at_exp));
            m_st_exp = 2'b00;
            m_tr_exp = 1'b0;
            if (m_load) begin
                f1 = (m_lv[5:3] > 3'd5) ? 3'd5 : m_lv[5:3];
                mv = int'(f1) * 8 + int'(m_lv[2:0]);
            end else if (m_en) begin
                ch_term  = m_dir ? (mv == 0) : (mv == 47);
                s0_term  = m_dir ? ((mv % 8) == 0) : ((mv % 8) == 7);
                m_st_exp = {ch_term, s0_term};
                m_tr_exp = ch_term;
                mv = m_dir ? (mv + 47) % 48 : (mv + 1) % 48;
            end
            tick();
            check("small_count", 32'(m_cnt), 32'({3'(mv / 8), 3'(mv % 8)}));
            check("small_stage_trig", 32'(m_st), 32'(m_st_exp));
            check("small_trig", 32'(m_tr), 32'(m_tr_exp));
            check("small_field1_bound", 32'(m_cnt[5:3] <= 3'd5), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
